// File: rtl/vga_pattern_pkg.sv
// Shared types and colour levels for the VGA test-pattern generator.
// Optional build macro VGA_PATTERN_GEN_SCROLL_EN is consumed by vga_pattern_gen.
package vga_pattern_pkg;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_CHECKER  = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_GRID     = 2'd3
  } pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 10-bit studio levels; users take the top COLOR_WIDTH bits
  localparam logic [9:0] LEVEL_ON  = 10'd721;
  localparam logic [9:0] LEVEL_OFF = 10'd64;

  // {r,g,b} on/off flags for the classic 8-bar sequence
  function automatic logic [2:0] bar_rgb(input logic [2:0] k);
    logic [2:0] rgb;
    case (k)
      3'd0:    rgb = 3'b111;
      3'd1:    rgb = 3'b110;
      3'd2:    rgb = 3'b011;
      3'd3:    rgb = 3'b010;
      3'd4:    rgb = 3'b101;
      3'd5:    rgb = 3'b100;
      3'd6:    rgb = 3'b001;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vga_pattern_pos.sv
// Raster position tracker: x/y counters, incremental colour-bar index, and
// registered sof/eol/last flags for the current pixel.
module vga_pattern_pos
  import vga_pattern_pkg::*;
#(
  parameter int H_WIDTH  = 12,
  parameter int V_WIDTH  = 12,
  parameter int NUM_BARS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        advance,
  input  logic [H_WIDTH-1:0]          h_size,
  input  logic [V_WIDTH-1:0]          v_size,
  input  logic [H_WIDTH-1:0]          bar_width,
  output logic [H_WIDTH-1:0]          x,
  output logic [V_WIDTH-1:0]          y,
  output logic [$clog2(NUM_BARS)-1:0] bar,
  output logic                        sof,
  output logic                        eol,
  output logic                        last
);

  localparam int BAR_BITS = $clog2(NUM_BARS);
  localparam logic [BAR_BITS-1:0] BAR_LAST = BAR_BITS'(NUM_BARS - 1);

  logic [H_WIDTH-1:0] bar_cnt;
  logic [H_WIDTH-1:0] x_inc;
  logic               y_last;
  logic               bar_sat;
  logic               bar_end;

  assign x_inc   = x + H_WIDTH'(1);
  assign y_last  = (y == v_size - V_WIDTH'(1));
  assign last    = eol && y_last;
  assign bar_sat = (bar == BAR_LAST);
  assign bar_end = (bar_cnt == bar_width - H_WIDTH'(1));

  // eol is precomputed one pixel ahead so the comparison never sits on the output path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      bar     <= '0;
      bar_cnt <= '0;
      sof     <= 1'b0;
      eol     <= 1'b0;
    end else if (load) begin
      x       <= '0;
      y       <= '0;
      bar     <= '0;
      bar_cnt <= '0;
      sof     <= 1'b1;
      eol     <= 1'b0;
    end else if (advance) begin
      if (eol) begin
        x       <= '0;
        bar     <= '0;
        bar_cnt <= '0;
        eol     <= 1'b0;
        sof     <= y_last;
        y       <= y_last ? '0 : y + V_WIDTH'(1);
      end else begin
        x   <= x_inc;
        sof <= 1'b0;
        eol <= (x_inc == h_size - H_WIDTH'(1));
        // once on the last bar the counter freezes, so remainder pixels stay there
        if (!bar_sat) begin
          if (bar_end) begin
            bar     <= bar + BAR_BITS'(1);
            bar_cnt <= '0;
          end else begin
            bar_cnt <= bar_cnt + H_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern source (bars/checker/gradient/grid) with valid/ready output.
// Define VGA_PATTERN_GEN_SCROLL_EN to scroll checker and gradient one pixel per frame.
module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int COLOR_WIDTH = 4,
  parameter int NUM_BARS    = 8,
  parameter int CHECK_SHIFT = 5,
  parameter int GRAD_SHIFT  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             pattern_sel,
  input  logic [H_WIDTH-1:0]     h_visible,
  input  logic [V_WIDTH-1:0]     v_visible,
  output logic                   m_pix_valid,
  output logic [COLOR_WIDTH-1:0] m_pix_red,
  output logic [COLOR_WIDTH-1:0] m_pix_grn,
  output logic [COLOR_WIDTH-1:0] m_pix_blu,
  output logic                   m_pix_sof,
  output logic                   m_pix_eol,
  input  logic                   m_pix_ready
);

  localparam int BAR_BITS = $clog2(NUM_BARS);
  localparam logic [COLOR_WIDTH-1:0] C_ON  = LEVEL_ON[9 -: COLOR_WIDTH];
  localparam logic [COLOR_WIDTH-1:0] C_OFF = LEVEL_OFF[9 -: COLOR_WIDTH];

  state_t             state;
  pattern_t           pattern;
  logic [H_WIDTH-1:0] h_lat;
  logic [V_WIDTH-1:0] v_lat;
  logic               valid;
  logic               xfer;
  logic               load;
  logic               last;
  logic               sof;
  logic               eol;
  logic [H_WIDTH-1:0] x;
  logic [V_WIDTH-1:0] y;
  logic [BAR_BITS-1:0] bar;
  logic [H_WIDTH-1:0] bar_width;

  assign valid     = (state == ST_RUN);
  assign xfer      = valid && m_pix_ready;
  assign load      = (state == ST_IDLE) && en;
  assign bar_width = h_lat >> BAR_BITS;

  // configuration is sampled only when a frame starts, so mid-frame changes wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pattern <= PAT_BARS;
      h_lat   <= '0;
      v_lat   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            pattern <= pattern_t'(pattern_sel);
            h_lat   <= h_visible;
            v_lat   <= v_visible;
            state   <= ST_RUN;
          end
        end
        default: begin
          if (xfer && last) begin
            if (en) begin
              pattern <= pattern_t'(pattern_sel);
              h_lat   <= h_visible;
              v_lat   <= v_visible;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  vga_pattern_pos #(
    .H_WIDTH  (H_WIDTH),
    .V_WIDTH  (V_WIDTH),
    .NUM_BARS (NUM_BARS)
  ) u_pos (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (xfer),
    .h_size    (h_lat),
    .v_size    (v_lat),
    .bar_width (bar_width),
    .x         (x),
    .y         (y),
    .bar       (bar),
    .sof       (sof),
    .eol       (eol),
    .last      (last)
  );

  logic                   xs_chk;
  logic [COLOR_WIDTH-1:0] xs_grad;

`ifdef VGA_PATTERN_GEN_SCROLL_EN
  logic [H_WIDTH-1:0] frame_cnt;
  logic [H_WIDTH-1:0] xs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (xfer && last) begin
      frame_cnt <= frame_cnt + H_WIDTH'(1);
    end
  end

  assign xs      = x + frame_cnt;
  assign xs_chk  = xs[CHECK_SHIFT];
  assign xs_grad = xs[GRAD_SHIFT +: COLOR_WIDTH];
`else
  assign xs_chk  = x[CHECK_SHIFT];
  assign xs_grad = x[GRAD_SHIFT +: COLOR_WIDTH];
`endif

  logic [2:0]             bar3;
  logic                   grid_on;
  logic [2:0]             rgb;
  logic [COLOR_WIDTH-1:0] red;
  logic [COLOR_WIDTH-1:0] grn;
  logic [COLOR_WIDTH-1:0] blu;

  assign bar3    = 3'(bar);
  assign grid_on = (x == '0) || (y == '0) || eol || (y == v_lat - V_WIDTH'(1)) ||
                   (x[CHECK_SHIFT-1:0] == '0) || (y[CHECK_SHIFT-1:0] == '0);

  always_comb begin
    rgb = 3'b000;
    red = C_OFF;
    grn = C_OFF;
    blu = C_OFF;
    case (pattern)
      PAT_BARS:    rgb = bar_rgb(bar3);
      PAT_CHECKER: rgb = {3{xs_chk ^ y[CHECK_SHIFT]}};
      PAT_GRID:    rgb = {3{grid_on}};
      default:     rgb = 3'b000;
    endcase
    if (pattern == PAT_GRADIENT) begin
      red = xs_grad;
      grn = xs_grad;
      blu = xs_grad;
    end else begin
      red = rgb[2] ? C_ON : C_OFF;
      grn = rgb[1] ? C_ON : C_OFF;
      blu = rgb[0] ? C_ON : C_OFF;
    end
  end

  // everything below is a function of registers only; ready never reaches an output
  assign m_pix_valid = valid;
  assign m_pix_sof   = valid && sof;
  assign m_pix_eol   = valid && eol;
  assign m_pix_red   = valid ? red : '0;
  assign m_pix_grn   = valid ? grn : '0;
  assign m_pix_blu   = valid ? blu : '0;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: a behavioural pixel model feeds an
// expected queue, accepted DUT pixels are collected and compared per scenario.
module tb_vga_pattern_gen;
  import vga_pattern_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [11:0] h_visible = 12'd0;
  logic [11:0] v_visible = 12'd0;
  logic        m_pix_ready = 1'b0;
  logic        m_pix_valid;
  logic [3:0]  m_pix_red;
  logic [3:0]  m_pix_grn;
  logic [3:0]  m_pix_blu;
  logic        m_pix_sof;
  logic        m_pix_eol;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_WIDTH     (12),
    .V_WIDTH     (12),
    .COLOR_WIDTH (4),
    .NUM_BARS    (8),
    .CHECK_SHIFT (5),
    .GRAD_SHIFT  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .h_visible   (h_visible),
    .v_visible   (v_visible),
    .m_pix_valid (m_pix_valid),
    .m_pix_red   (m_pix_red),
    .m_pix_grn   (m_pix_grn),
    .m_pix_blu   (m_pix_blu),
    .m_pix_sof   (m_pix_sof),
    .m_pix_eol   (m_pix_eol),
    .m_pix_ready (m_pix_ready)
  );

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       sof;
    logic       eol;
  } pix_t;

  pix_t exp_q[$];
  pix_t got_q[$];
  pix_t ref_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   hold_err = 0;
  int   frame_no = 0;

  function automatic pix_t model(input int sel, input int x, input int y,
                                 input int h, input int v, input int fr);
    logic [11:0] xs;
    logic [11:0] yv;
    logic [2:0]  rgb;
    logic [2:0]  tbl [8];
    logic [3:0]  gray;
    int          k;
    int          scroll;
    pix_t        p;
    tbl = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    scroll = 0;
`ifdef VGA_PATTERN_GEN_SCROLL_EN
    scroll = fr;
`endif
    xs  = 12'(x + scroll);
    yv  = 12'(y);
    rgb = 3'b000;
    case (sel)
      0: begin
        k = x / (h / 8);
        if (k > 7) k = 7;
        rgb = tbl[k];
      end
      1: rgb = {3{xs[5] ^ yv[5]}};
      3: rgb = {3{(x == 0) || (y == 0) || (x == h - 1) || (y == v - 1) ||
                  (x % 32 == 0) || (y % 32 == 0)}};
      default: rgb = 3'b000;
    endcase
    gray  = xs[6:3];
    p.r   = (sel == 2) ? gray : (rgb[2] ? 4'hB : 4'h1);
    p.g   = (sel == 2) ? gray : (rgb[1] ? 4'hB : 4'h1);
    p.b   = (sel == 2) ? gray : (rgb[0] ? 4'hB : 4'h1);
    p.sof = (x == 0) && (y == 0);
    p.eol = (x == h - 1);
    return p;
  endfunction

  task automatic push_frame(input int sel, input int h, input int v, input int npix);
    for (int i = 0; i < npix; i++) exp_q.push_back(model(sel, i % h, i / h, h, v, frame_no));
    if (npix == h * v) frame_no++;
  endtask

  // Accept n pixels; outputs seen while stalled must match the next cycle's
  task automatic collect(input int n, input bit rnd, input int budget);
    pix_t cur;
    pix_t held;
    bit   stalled;
    bit   r;
    int   k;
    stalled = 1'b0;
    k = 0;
    held = '0;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      @(negedge clk);
      cur = {m_pix_red, m_pix_grn, m_pix_blu, m_pix_sof, m_pix_eol};
      if (stalled && (cur !== held || m_pix_valid !== 1'b1)) hold_err++;
      if (k == n) begin
        m_pix_ready = 1'b0;
        return;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      m_pix_ready = r;
      if (m_pix_valid && r) begin
        got_q.push_back(cur);
        k++;
      end
      stalled = m_pix_valid && !r;
      held = cur;
    end
    m_pix_ready = 1'b0;
  endtask

  task automatic do_reset(input int sel, input int h, input int v);
    m_pix_ready = 1'b0;
    en = 1'b0;
    pattern_sel = 2'(sel);
    h_visible = 12'(h);
    v_visible = 12'(v);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    exp_q.delete();
    got_q.delete();
    frame_no = 0;
    hold_err = 0;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_pix_valid, m_pix_sof, m_pix_eol, m_pix_red, m_pix_grn, m_pix_blu} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0",
               {m_pix_valid, m_pix_sof, m_pix_eol, m_pix_red, m_pix_grn, m_pix_blu});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if (m_pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_without_en: valid got %b want 0", m_pix_valid);
    end
  endtask

  task automatic test_bars();
    int   idx [4];
    pix_t want [4];
    pix_t e;
    pix_t g;
    idx  = '{0, 79, 80, 639};
    want = '{{4'hB, 4'hB, 4'hB, 1'b1, 1'b0}, {4'hB, 4'hB, 4'hB, 1'b0, 1'b0},
             {4'hB, 4'hB, 4'h1, 1'b0, 1'b0}, {4'h1, 4'h1, 4'h1, 1'b0, 1'b1}};
    do_reset(0, 640, 480);
    push_frame(0, 640, 480, 640);
    collect(640, 1'b0, 1000);
    vectors++;
    if (got_q.size() != 640) begin
      miscompares++;
      $display("FAIL bars_count: got %0d want 640", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got_q[idx[i]] !== want[i]) begin
          miscompares++;
          $display("FAIL bars_x%0d: got %h want %h", idx[i], got_q[idx[i]], want[i]);
        end
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bars_pix: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_backpressure();
    pix_t e;
    pix_t g;
    pix_t rf;
    do_reset(3, 40, 34);
    push_frame(3, 40, 34, 1360);
    push_frame(3, 40, 34, 40);
    collect(1400, 1'b0, 3000);
    ref_q = got_q;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL grid_pix: got %h want %h", g, e);
      end
    end
    do_reset(3, 40, 34);
    collect(1400, 1'b1, 8000);
    vectors++;
    if (got_q.size() != ref_q.size() || ref_q.size() != 1400) begin
      miscompares++;
      $display("FAIL bp_count: got %0d want %0d", got_q.size(), ref_q.size());
    end
    while (got_q.size() > 0 && ref_q.size() > 0) begin
      rf = ref_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== rf) begin
        miscompares++;
        $display("FAIL bp_pix: got %h want %h", g, rf);
      end
    end
    vectors++;
    if (hold_err != 0) begin
      miscompares++;
      $display("FAIL bp_hold: got %0d unstable stalls want 0", hold_err);
    end
  endtask

  task automatic test_boundary();
    pix_t e;
    pix_t g;
    pix_t w_eol;
    pix_t w_sof;
    pix_t w_chk;
    w_eol = {4'h1, 4'h1, 4'h1, 1'b0, 1'b1};
    w_sof = {4'h1, 4'h1, 4'h1, 1'b1, 1'b0};
    w_chk = {4'hB, 4'hB, 4'hB, 1'b0, 1'b0};
    do_reset(0, 64, 2);
    push_frame(0, 64, 2, 128);
    push_frame(1, 64, 2, 128);
    collect(10, 1'b0, 100);
    pattern_sel = 2'd1;
    collect(246, 1'b0, 600);
    vectors++;
    if (got_q.size() != 256) begin
      miscompares++;
      $display("FAIL bnd_count: got %0d want 256", got_q.size());
    end else begin
      vectors++;
      if (got_q[127] !== w_eol) begin
        miscompares++;
        $display("FAIL bnd_last_bar: got %h want %h", got_q[127], w_eol);
      end
      vectors++;
      if (got_q[128] !== w_sof) begin
        miscompares++;
        $display("FAIL bnd_chk_sof: got %h want %h", got_q[128], w_sof);
      end
      vectors++;
      if (got_q[160] !== w_chk) begin
        miscompares++;
        $display("FAIL bnd_chk_32_0: got %h want %h", got_q[160], w_chk);
      end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL bnd_pix: got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_stop();
    pix_t e;
    pix_t g;
    do_reset(2, 16, 2);
    push_frame(2, 16, 2, 32);
    collect(5, 1'b0, 50);
    en = 1'b0;
    collect(27, 1'b0, 100);
    vectors++;
    if (m_pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stop_valid: got %b want 0", m_pix_valid);
    end
    vectors++;
    if (dut.state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL stop_state: got %0d want %0d", dut.state, ST_IDLE);
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL stop_pix: got %h want %h", g, e);
      end
    end
    collect(1, 1'b0, 10);
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL stop_idle_hold: got %0d pixels want 0", got_q.size());
    end
    got_q.delete();
    en = 1'b1;
    push_frame(2, 16, 2, 1);
    collect(1, 1'b0, 10);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      miscompares++;
      $display("FAIL stop_restart: got %0d pixels want 1 sof pixel %h", got_q.size(), exp_q[0]);
    end
  endtask

  task automatic test_reset_midline();
    pix_t e;
    pix_t g;
    pix_t w0;
    w0 = {4'hB, 4'hB, 4'hB, 1'b1, 1'b0};
    do_reset(0, 32, 4);
    push_frame(0, 32, 4, 10);
    collect(10, 1'b0, 50);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL rst_pre_pix: got %h want %h", g, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({m_pix_valid, m_pix_sof, m_pix_eol, m_pix_red, m_pix_grn, m_pix_blu} !== 15'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {m_pix_valid, m_pix_sof, m_pix_eol, m_pix_red, m_pix_grn, m_pix_blu});
    end
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    collect(1, 1'b0, 10);
    vectors++;
    if (got_q.size() != 1 || got_q[0] !== w0) begin
      miscompares++;
      $display("FAIL rst_first_pix: got %0d pixels want 1 pixel %h", got_q.size(), w0);
    end
  endtask

`ifdef VGA_PATTERN_GEN_SCROLL_EN
  task automatic test_scroll();
    pix_t e;
    pix_t g;
    pix_t frames[$];
    do_reset(2, 16, 1);
    for (int f = 0; f < 4; f++) push_frame(2, 16, 1, 16);
    collect(64, 1'b0, 200);
    frames = got_q;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL scroll_pix: got %h want %h", g, e);
      end
    end
    if (frames.size() == 64) begin
      for (int n = 1; n < 4; n++) begin
        for (int x = 0; x < 16 - n; x++) begin
          vectors++;
          if (frames[n * 16 + x][13:2] !== frames[x + n][13:2]) begin
            miscompares++;
            $display("FAIL scroll_f%0d_x%0d: got %h want %h", n, x,
                     frames[n * 16 + x][13:2], frames[x + n][13:2]);
          end
        end
      end
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL scroll_count: got %0d want 64", frames.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_bars();
    test_backpressure();
    test_boundary();
    test_stop();
    test_reset_midline();
`ifdef VGA_PATTERN_GEN_SCROLL_EN
    test_scroll();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
